// File: rtl/ring_arb_pkg.sv
// ---------------------------------------------------------------------------
// ring_arb_pkg
//   Shared types and helpers for the ring round-robin arbiter.
//   - state_t       : arbiter FSM states (IDLE, GRANT, GAP)
//   - rotl1()       : rotate a one-hot token left by one within w bits
//   - onehot_to_idx : binary index of the set bit of a one-hot vector
//   Helpers operate on MAX_W-bit vectors; callers zero-extend / truncate
//   with width casts so the arbiter can be any WIDTH up to MAX_W.
// ---------------------------------------------------------------------------
package ring_arb_pkg;

   localparam int MAX_W   = 64;
   localparam int MAX_IDW = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   // Bit i moves to bit (i+1) mod w; bits at or above w are ignored.
   function automatic logic [MAX_W-1:0] rotl1(input logic [MAX_W-1:0] v,
                                              input int              w);
      logic [MAX_W-1:0] r;
      r = '0;
      for (int i = 0; i < MAX_W; i++) begin
         if (i < w && v[i]) r[(i + 1) % w] = 1'b1;
      end
      return r;
   endfunction

   // OR of the indices of all set bits; exact for one-hot inputs.
   function automatic logic [MAX_IDW-1:0] onehot_to_idx(input logic [MAX_W-1:0] v);
      logic [MAX_IDW-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_W; i++) begin
         if (v[i]) idx = idx | MAX_IDW'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/ring_rr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational rotating-priority select. Returns the first set bit of
//   i_req found when scanning upward from the one-hot token position i_ptr,
//   wrapping around past the top bit.
//   Ports:
//     i_req [WIDTH] : request vector
//     i_ptr [WIDTH] : one-hot priority token
//     o_sel [WIDTH] : one-hot selection (zero when i_req is zero)
// ---------------------------------------------------------------------------
module rr_pick #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] i_req,
   input  logic [WIDTH-1:0] i_ptr,
   output logic [WIDTH-1:0] o_sel
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] w_hi;
   logic [WIDTH-1:0] w_src;

   always_comb begin
      // ~(ptr-1) masks the token bit and everything above it. If nothing is
      // requesting there, the wrap-around search is just the lowest request.
      w_hi  = i_req & ~(i_ptr - ONE);
      w_src = (|w_hi) ? w_hi : i_req;
      // Isolate the lowest set bit.
      o_sel = w_src & (~w_src + ONE);
   end

endmodule

// File: rtl/ring_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ring_rr_arbiter
//   Round-robin arbiter sharing one resource among WIDTH requesters. A
//   one-hot ring token (ptr) marks the highest-priority requester; it moves
//   to the position just above a grant when that grant is released. Each
//   grant lasts at most MAX_HOLD cycles and consecutive grants are separated
//   by one turnaround (GAP) cycle with gnt=0.
//
//   Handshake: a requester holds req high while it wants the resource; the
//   grant appears one cycle after req is sampled and is kept while req stays
//   high, en stays high and the hold limit is not reached. Dropping req
//   releases the grant at the next edge. There is no request latching.
//
//   Ports:
//     clk       : clock, rising edge
//     rstn      : asynchronous active-low reset
//     en        : arbitration enable; low releases and blocks grants
//     req       : [WIDTH] request lines
//     gnt       : [WIDTH] registered one-hot grant
//     gnt_valid : registered |gnt
//     gnt_id    : [IDW] index of granted requester (held when idle)
//     ptr       : [WIDTH] one-hot ring token
//     hold_cnt  : [HCW] cycles into the current grant, 0 when idle
//     dbg_state : FSM state for observation
// ---------------------------------------------------------------------------
module ring_rr_arbiter
   import ring_arb_pkg::*;
#(
   parameter  int WIDTH    = 4,
   parameter  int MAX_HOLD = 4,
   localparam int IDW      = $clog2(WIDTH),
   localparam int HCW      = $clog2(MAX_HOLD + 1)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic [WIDTH-1:0] req,
   output logic [WIDTH-1:0] gnt,
   output logic             gnt_valid,
   output logic [IDW-1:0]   gnt_id,
   output logic [WIDTH-1:0] ptr,
   output logic [HCW-1:0]   hold_cnt,
   output state_t           dbg_state
);

   localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD);
   localparam logic [HCW-1:0] HOLD_ONE = HCW'(1);

   state_t           r_state;
   logic [WIDTH-1:0] r_gnt;
   logic             r_gnt_valid;
   logic [IDW-1:0]   r_gnt_id;
   logic [WIDTH-1:0] r_ptr;
   logic [HCW-1:0]   r_hold;

   logic [WIDTH-1:0] w_sel;
   logic             w_release;

   rr_pick #(.WIDTH(WIDTH)) u_pick (
      .i_req (req),
      .i_ptr (r_ptr),
      .o_sel (w_sel)
   );

   // The granted requester is identified by r_gnt itself, so req & r_gnt
   // being zero means the holder has dropped its request.
   assign w_release = ~(|(req & r_gnt)) | ~en | (r_hold == HOLD_MAX);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= IDLE;
         r_gnt       <= '0;
         r_gnt_valid <= 1'b0;
         r_gnt_id    <= '0;
         r_ptr       <= WIDTH'(1);
         r_hold      <= '0;
      end else begin
         case (r_state)
            IDLE, GAP: begin
               if (en && |req) begin
                  r_state     <= GRANT;
                  r_gnt       <= w_sel;
                  r_gnt_valid <= 1'b1;
                  r_gnt_id    <= IDW'(onehot_to_idx(MAX_W'(w_sel)));
                  r_hold      <= HOLD_ONE;
               end else begin
                  r_state     <= IDLE;
                  r_gnt       <= '0;
                  r_gnt_valid <= 1'b0;
                  r_hold      <= '0;
               end
            end
            GRANT: begin
               if (w_release) begin
                  r_state     <= GAP;
                  r_gnt       <= '0;
                  r_gnt_valid <= 1'b0;
                  r_hold      <= '0;
                  r_ptr       <= WIDTH'(rotl1(MAX_W'(r_gnt), WIDTH));
               end else begin
                  r_hold      <= r_hold + HOLD_ONE;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_gnt       <= '0;
               r_gnt_valid <= 1'b0;
               r_hold      <= '0;
            end
         endcase
      end
   end

   assign gnt       = r_gnt;
   assign gnt_valid = r_gnt_valid;
   assign gnt_id    = r_gnt_id;
   assign ptr       = r_ptr;
   assign hold_cnt  = r_hold;
   assign dbg_state = r_state;

endmodule
